// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid bit, stall hold, flush bubble and saturating event counters.
// Latency: 1 cycle from EX_* inputs to MEM_* outputs; counters update on the same edge.
// Backpressure: stall holds every stage field; flush overrides stall and loads a bubble.
module ex_mem_pipe_reg #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5,
   parameter int F3_W    = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               cnt_clr,
   input  logic               EX_valid,
   input  logic               EX_MemtoReg,
   input  logic               EX_RegWrite,
   input  logic               EX_MemRead,
   input  logic               EX_MemWrite,
   input  logic               EX_Branch,
   input  logic               EX_Jump,
   input  logic               EX_zero,
   input  logic               EX_s_less,
   input  logic               EX_u_less,
   input  logic [XLEN-1:0]    EX_PCSum,
   input  logic [XLEN-1:0]    EX_ALUresult,
   input  logic [XLEN-1:0]    EX_RegData2,
   input  logic [F3_W-1:0]    EX_funct3,
   input  logic [RADDR_W-1:0] EX_rdReg,
   output logic               MEM_valid,
   output logic               MEM_MemtoReg,
   output logic               MEM_RegWrite,
   output logic               MEM_MemRead,
   output logic               MEM_MemWrite,
   output logic               MEM_Branch,
   output logic               MEM_Jump,
   output logic               MEM_zero,
   output logic               MEM_s_less,
   output logic               MEM_u_less,
   output logic [XLEN-1:0]    MEM_PCSum,
   output logic [XLEN-1:0]    MEM_ALUresult,
   output logic [XLEN-1:0]    MEM_RegData2,
   output logic [F3_W-1:0]    MEM_funct3,
   output logic [RADDR_W-1:0] MEM_rdReg,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   typedef struct packed {
      logic               valid;
      logic               memtoreg;
      logic               regwrite;
      logic               memread;
      logic               memwrite;
      logic               branch;
      logic               jump;
      logic               zero;
      logic               s_less;
      logic               u_less;
      logic [XLEN-1:0]    pcsum;
      logic [XLEN-1:0]    aluresult;
      logic [XLEN-1:0]    regdata2;
      logic [F3_W-1:0]    funct3;
      logic [RADDR_W-1:0] rdreg;
   } stage_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_t           r_stage;
   stage_t           w_stage_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_stall_evt;

   // A flush counts only as a flush, never also as a stall.
   assign w_stall_evt = stall & ~flush;

   // Next stage contents: flush clears everything, stall holds, otherwise load with
   // control bits gated by EX_valid so a bubble can never write memory or registers.
   always_comb begin
      w_stage_nxt = r_stage;
      if (flush) begin
         w_stage_nxt = '0;
      end else if (!stall) begin
         w_stage_nxt.valid     = EX_valid;
         w_stage_nxt.memtoreg  = EX_MemtoReg & EX_valid;
         w_stage_nxt.regwrite  = EX_RegWrite & EX_valid;
         w_stage_nxt.memread   = EX_MemRead  & EX_valid;
         w_stage_nxt.memwrite  = EX_MemWrite & EX_valid;
         w_stage_nxt.branch    = EX_Branch   & EX_valid;
         w_stage_nxt.jump      = EX_Jump     & EX_valid;
         w_stage_nxt.zero      = EX_zero;
         w_stage_nxt.s_less    = EX_s_less;
         w_stage_nxt.u_less    = EX_u_less;
         w_stage_nxt.pcsum     = EX_PCSum;
         w_stage_nxt.aluresult = EX_ALUresult;
         w_stage_nxt.regdata2  = EX_RegData2;
         w_stage_nxt.funct3    = EX_funct3;
         w_stage_nxt.rdreg     = EX_rdReg;
      end
   end

   // Stage register; reset clears to a bubble immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else begin
         r_stage <= w_stage_nxt;
      end
   end

   // Stall counter: clear wins over increment, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   // Flush counter: clear wins over increment, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush_cnt <= '0;
      end else if (cnt_clr) begin
         r_flush_cnt <= '0;
      end else if (flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
         r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
   end

   assign MEM_valid     = r_stage.valid;
   assign MEM_MemtoReg  = r_stage.memtoreg;
   assign MEM_RegWrite  = r_stage.regwrite;
   assign MEM_MemRead   = r_stage.memread;
   assign MEM_MemWrite  = r_stage.memwrite;
   assign MEM_Branch    = r_stage.branch;
   assign MEM_Jump      = r_stage.jump;
   assign MEM_zero      = r_stage.zero;
   assign MEM_s_less    = r_stage.s_less;
   assign MEM_u_less    = r_stage.u_less;
   assign MEM_PCSum     = r_stage.pcsum;
   assign MEM_ALUresult = r_stage.aluresult;
   assign MEM_RegData2  = r_stage.regdata2;
   assign MEM_funct3    = r_stage.funct3;
   assign MEM_rdReg     = r_stage.rdreg;
   assign stall_cnt     = r_stall_cnt;
   assign flush_cnt     = r_flush_cnt;

endmodule
